// File: rtl/chroma_pkg.sv
// chroma_pkg: constants, sample type and output arithmetic helpers shared by
// the chroma modulator, its bus interface and the sine/cosine table.
package chroma_pkg;

  // Per-clock phase increments for a 48 MHz clock and a 32-bit accumulator.
  localparam logic [31:0] PAL_FREQ_WORD_48M  = 32'd396713490;
  localparam logic [31:0] NTSC_FREQ_WORD_48M = 32'd320292264;

  typedef logic signed [7:0] sample_t;

  // NTSC burst sits on -U. PAL burst uses 14 per axis, about 20/sqrt(2).
  localparam sample_t BURST_AMP_NTSC = 8'sd20;
  localparam sample_t BURST_AMP_PAL  = 8'sd14;

  localparam int LUT_IDX_BITS  = 8;
  localparam int LUT_QTR_DEPTH = 64;
  localparam int LUT_AMP       = 127;

  // (s + 64) >>> 7 on the 17-bit sum. The result always fits in 10 bits.
  function automatic logic signed [9:0] round_s17(input logic signed [16:0] s);
    logic signed [16:0] t;
    t = s + 17'sd64;
    return 10'(t >>> 7);
  endfunction

  // Clamp the rounded value to the signed 8-bit output range.
  function automatic sample_t sat8(input logic signed [9:0] r);
    if (r > 10'sd127)
      return 8'h7F;
    else if (r < -10'sd128)
      return 8'h80;
    else
      return 8'(r);
  endfunction

endpackage

// File: rtl/chroma_modulator_if.sv
// chroma_modulator_if: picture-side inputs and modulated output of the chroma
// modulator. Defining CHROMA_PHASE_RESET_EN adds the frame_start pulse.
interface chroma_modulator_if;
  import chroma_pkg::*;

  logic    pal_mode;
  sample_t u;
  sample_t v;
  logic    newline;
  logic    burst_window;
  logic    active;
`ifdef CHROMA_PHASE_RESET_EN
  logic    frame_start;
`endif
  sample_t out;

  modport master (
    output pal_mode, u, v, newline, burst_window, active,
`ifdef CHROMA_PHASE_RESET_EN
    output frame_start,
`endif
    input  out
  );

  modport slave (
    input  pal_mode, u, v, newline, burst_window, active,
`ifdef CHROMA_PHASE_RESET_EN
    input  frame_start,
`endif
    output out
  );

endinterface

// File: rtl/chroma_modulator_sine_lut.sv
// sine_lut: combinational 256-point sine/cosine from a 64-entry quarter-wave
// table with amplitude 127. Index bits [7:6] pick the quadrant.
module sine_lut
  import chroma_pkg::*;
(
  input  logic [7:0] i_idx,
  output sample_t    o_sin,
  output sample_t    o_cos
);

  // round(127 * sin(2*pi*k/256)) for k = 0..63. The 90 degree point (127)
  // is not in the table and is produced by the quadrant logic.
  localparam logic [6:0] QTR [LUT_QTR_DEPTH] = '{
      7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
      7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
      7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
      7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
      7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
      7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
      7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
      7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127};

  // Odd quadrants read the table mirrored (64 - a). The upper half is negated.
  function automatic sample_t sin_of(input logic [7:0] idx);
    logic [5:0] a;
    logic [6:0] mag;
    a = idx[5:0];
    if (idx[6])
      mag = (a == 6'd0) ? 7'(LUT_AMP) : QTR[6'd0 - a];
    else
      mag = QTR[a];
    return idx[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  // cos is the sine a quarter turn ahead. The 8-bit index wraps.
  always_comb begin
    o_sin = sin_of(i_idx);
    o_cos = sin_of(i_idx + 8'd64);
  end

endmodule

// File: rtl/chroma_modulator.sv
// chroma_modulator: DDS quadrature chroma modulator with burst insertion and
// PAL V-axis line switch. Out = sat(round((u'*sin + vsign*v'*cos) / 128)).
// Latency: out updates on the third rising edge, counting the edge that samples
// the inputs. Defining CHROMA_PHASE_RESET_EN adds bus.frame_start, which zeroes
// the phase and forces vsign to +1.
module chroma_modulator
  import chroma_pkg::*;
#(
  parameter int unsigned           PHASE_BITS     = 32,
  parameter logic [PHASE_BITS-1:0] PAL_FREQ_WORD  = PHASE_BITS'(PAL_FREQ_WORD_48M),
  parameter logic [PHASE_BITS-1:0] NTSC_FREQ_WORD = PHASE_BITS'(NTSC_FREQ_WORD_48M)
) (
  input logic               clk,
  input logic               rst_n,
  chroma_modulator_if.slave bus
);

  logic [PHASE_BITS-1:0] r_phase;
  logic                  r_vneg;       // 1 means vsign = -1
  logic [7:0]            w_idx;
  sample_t               w_sin, w_cos;
  logic                  w_vneg;
  sample_t               w_u_src, w_v_src;

  sample_t               r_u1, r_v1, r_sin1, r_cos1;
  logic                  r_vneg1;
  logic signed [8:0]     w_v9;
  logic signed [15:0]    r_pu2, r_pv2;
  logic signed [16:0]    w_sum;
  sample_t               r_out;

  assign w_idx = r_phase[PHASE_BITS-1 -: LUT_IDX_BITS];

  sine_lut u_lut (
    .i_idx (w_idx),
    .o_sin (w_sin),
    .o_cos (w_cos)
  );

  // Phase accumulator. A mode switch changes only the increment, not the phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_phase <= '0;
`ifdef CHROMA_PHASE_RESET_EN
    else if (bus.frame_start)
      r_phase <= '0;
`endif
    else
      r_phase <= r_phase + (bus.pal_mode ? PAL_FREQ_WORD : NTSC_FREQ_WORD);
  end

  // PAL line switch. It toggles on newline, stays at +1 in NTSC, and a new value
  // only reaches the samples that follow the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_vneg <= 1'b0;
`ifdef CHROMA_PHASE_RESET_EN
    else if (bus.frame_start)
      r_vneg <= 1'b0;
`endif
    else if (!bus.pal_mode)
      r_vneg <= 1'b0;
    else if (bus.newline)
      r_vneg <= ~r_vneg;
  end

  // In NTSC the sign is +1 even in the cycle where the register is still
  // clearing after a mode change.
  assign w_vneg = bus.pal_mode & r_vneg;

  // Source select. Burst has priority over picture. Blanking modulates zero.
  always_comb begin
    w_u_src = '0;
    w_v_src = '0;
    if (bus.burst_window) begin
      if (bus.pal_mode) begin
        w_u_src = -BURST_AMP_PAL;
        w_v_src = BURST_AMP_PAL;
      end else begin
        w_u_src = -BURST_AMP_NTSC;
      end
    end else if (bus.active) begin
      w_u_src = bus.u;
      w_v_src = bus.v;
    end
  end

  // V is widened to 9 bits before negation so -(-128) stays +128.
  assign w_v9  = r_vneg1 ? -$signed({r_v1[7], r_v1}) : $signed({r_v1[7], r_v1});
  assign w_sum = 17'(r_pu2) + 17'(r_pv2);

  // Three-stage pipeline: operands, products, then round and saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_u1    <= '0;
      r_v1    <= '0;
      r_sin1  <= '0;
      r_cos1  <= '0;
      r_vneg1 <= 1'b0;
      r_pu2   <= '0;
      r_pv2   <= '0;
      r_out   <= '0;
    end else begin
      r_u1    <= w_u_src;
      r_v1    <= w_v_src;
      r_sin1  <= w_sin;
      r_cos1  <= w_cos;
      r_vneg1 <= w_vneg;
      r_pu2   <= 16'(r_u1) * 16'(r_sin1);
      r_pv2   <= 16'(w_v9) * 16'(r_cos1);
      r_out   <= sat8(round_s17(w_sum));
    end
  end

  assign bus.out = r_out;

endmodule

// File: tb/tb_chroma_modulator.sv
// tb_chroma_modulator: directed vector tables for two modulator instances.
// dut_a steps 90 degrees per clock and dut_b steps 45 degrees per clock.
// A hand sequence covers reset asserted in the middle of a line.
module tb_chroma_modulator;
  import chroma_pkg::*;

  typedef struct {
    logic    pal;
    sample_t u;
    sample_t v;
    logic    nl;
    logic    bw;
    logic    act;
    logic    fs;
    sample_t exp_out;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tab[$];

  chroma_modulator_if ifa ();
  chroma_modulator_if ifb ();

  chroma_modulator #(
    .PAL_FREQ_WORD  (32'h4000_0000),
    .NTSC_FREQ_WORD (32'h4000_0000)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  chroma_modulator #(
    .PAL_FREQ_WORD  (32'h2000_0000),
    .NTSC_FREQ_WORD (32'h2000_0000)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input bit pal, input int u, input int v, input bit nl,
                              input bit bw, input bit act, input bit fs, input int e);
    vec_t t;
    t.pal = pal; t.u = 8'(u); t.v = 8'(v); t.nl = nl;
    t.bw = bw; t.act = act; t.fs = fs; t.exp_out = 8'(e);
    return t;
  endfunction

  function automatic vec_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic drive(input vec_t t);
    ifa.pal_mode = t.pal; ifa.u = t.u; ifa.v = t.v; ifa.newline = t.nl;
    ifa.burst_window = t.bw; ifa.active = t.act;
    ifb.pal_mode = t.pal; ifb.u = t.u; ifb.v = t.v; ifb.newline = t.nl;
    ifb.burst_window = t.bw; ifb.active = t.act;
`ifdef CHROMA_PHASE_RESET_EN
    ifa.frame_start = t.fs;
    ifb.frame_start = t.fs;
`endif
  endtask

  task automatic check(input string name, input sample_t got, input sample_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: out=%0d expected=%0d", name, got, want);
    end
  endtask

  // Ends on a falling edge with reset just released. The next rising edge
  // samples with phase 0.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(idle());
    repeat (2) @(negedge clk);
    check("reset_out_a", ifa.out, 8'sd0);
    check("reset_out_b", ifb.out, 8'sd0);
    rst_n = 1'b1;
  endtask

  // Vector j is sampled at rising edge j. Its result is seen after edge j+2.
  task automatic run_tab(input bit sel, input string tag);
    sample_t got;
    for (int j = 0; j < tab.size() + 2; j++) begin
      if (j < tab.size()) drive(tab[j]);
      else                drive(idle());
      @(negedge clk);
      got = sel ? ifb.out : ifa.out;
      if (j >= 2) check($sformatf("%s[%0d]", tag, j - 2), got, tab[j - 2].exp_out);
      else        check($sformatf("%s_fill%0d", tag, j), got, 8'sd0);
    end
  endtask

  initial begin
    int p4[4];
    int mr[4];
    drive(idle());

    // dut_a: the sample phase index is 64*pos mod 256 (0, 90, 180, 270 degrees).
    tab.delete();
    for (int k = 0; k < 4; k++) tab.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));
    p4 = '{0, 126, 0, -126};
    for (int k = 0; k < 8; k++) tab.push_back(mk(0, 127, 0, 0, 0, 1, 0, p4[k % 4]));
    p4 = '{126, 0, -126, 0};
    for (int k = 0; k < 4; k++) tab.push_back(mk(1, 0, 127, 0, 0, 1, 0, p4[k]));
    tab.push_back(mk(1, 0, 127, 1, 0, 1, 0, 126));     // newline: pre-toggle sign
    tab.push_back(mk(1, 0, 127, 0, 0, 1, 0, 0));
    tab.push_back(mk(1, 0, 127, 0, 0, 1, 0, 126));
    tab.push_back(mk(1, 0, 127, 0, 0, 1, 0, 0));
    tab.push_back(mk(1, 0, 127, 0, 0, 1, 0, -126));
    tab.push_back(mk(1, 0, 127, 0, 0, 1, 0, 0));
    tab.push_back(mk(1, 0, 127, 0, 0, 1, 0, 126));
    tab.push_back(mk(1, 0, 127, 0, 0, 1, 0, 0));
    tab.push_back(mk(1, 0, 127, 1, 0, 1, 0, -126));    // second newline
    tab.push_back(mk(1, 0, 127, 0, 0, 1, 0, 0));
    tab.push_back(mk(1, 0, 127, 0, 0, 1, 0, -126));
    tab.push_back(mk(1, 0, 127, 0, 0, 1, 0, 0));
    tab.push_back(mk(1, 0, 127, 0, 0, 1, 0, 126));     // back to original
    tab.push_back(mk(1, 0, 127, 1, 0, 1, 0, 0));       // toggle to -1
    tab.push_back(mk(0, 0, 127, 0, 0, 1, 0, -126));    // NTSC forces +1
    tab.push_back(mk(0, 0, 127, 0, 0, 1, 0, 0));
    tab.push_back(mk(1, 0, 127, 0, 0, 1, 0, 126));     // PAL resumes at +1
    tab.push_back(mk(0, 50, 0, 0, 1, 1, 0, -20));      // NTSC burst at 90 deg
    tab.push_back(mk(0, 50, 0, 0, 1, 1, 0, 0));
    tab.push_back(mk(0, 50, 0, 0, 1, 1, 0, 20));
    tab.push_back(mk(0, 50, 0, 0, 1, 1, 0, 0));
    tab.push_back(mk(0, 50, 0, 0, 0, 0, 0, 0));        // blanking
    tab.push_back(mk(1, 50, 0, 0, 1, 1, 0, -14));      // PAL burst, vsign +1
    tab.push_back(mk(1, 50, 0, 0, 1, 1, 0, 14));
    tab.push_back(mk(1, 50, 0, 1, 1, 1, 0, 14));       // burst+newline: pre-toggle
    tab.push_back(mk(1, 50, 0, 0, 1, 1, 0, -14));
    tab.push_back(mk(1, 50, 0, 0, 1, 1, 0, 14));       // vsign -1 flips V axis
    tab.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0));
    tab.push_back(mk(1, 0, -128, 0, 0, 1, 0, 127));    // -(-128) carried at 9 bits
    tab.push_back(mk(1, 0, -128, 0, 0, 1, 0, 0));
    tab.push_back(mk(1, 0, -128, 0, 0, 1, 0, -127));
    tab.push_back(mk(1, 100, 100, 0, 0, 0, 0, 0));     // PAL blanking
    do_reset();
    run_tab(1'b0, "A");

    // dut_b: the sample phase index is 32*pos (45 degree steps). Saturation
    // occurs at 45 and 225 degrees.
    tab.delete();
    tab.push_back(mk(0, -128, -128, 0, 0, 1, 0, -127));
    tab.push_back(mk(0, -128, -128, 0, 0, 1, 0, -128));
    tab.push_back(mk(0, -128, -128, 0, 0, 1, 0, -127));
    tab.push_back(mk(0, -128, -128, 0, 0, 1, 0, 0));
    tab.push_back(mk(0, 127, 127, 0, 0, 1, 0, -126));
    tab.push_back(mk(0, 127, 127, 0, 0, 1, 0, -128));
    tab.push_back(mk(0, 127, 127, 0, 0, 1, 0, -126));
    tab.push_back(mk(0, 127, 127, 0, 0, 1, 0, 0));
    tab.push_back(mk(0, 127, 127, 0, 0, 1, 0, 126));
    tab.push_back(mk(0, 127, 127, 0, 0, 1, 0, 127));
    do_reset();
    run_tab(1'b1, "B");

`ifdef CHROMA_PHASE_RESET_EN
    // frame_start zeroes the phase and the sign. It wins over a coincident newline.
    tab.delete();
    tab.push_back(mk(1, 0, 127, 1, 0, 1, 0, 126));
    tab.push_back(mk(1, 0, 127, 0, 0, 1, 0, 0));
    tab.push_back(mk(1, 0, 127, 0, 0, 1, 1, 126));
    tab.push_back(mk(1, 0, 127, 0, 0, 1, 0, 126));     // restarts at 0 deg, +1
    tab.push_back(mk(1, 0, 127, 0, 0, 1, 0, 0));
    tab.push_back(mk(1, 0, 127, 1, 0, 1, 1, -126));
    tab.push_back(mk(1, 0, 127, 0, 0, 1, 0, 126));
    tab.push_back(mk(1, 0, 127, 0, 0, 1, 0, 0));
    do_reset();
    run_tab(1'b0, "C");
`endif

    // Reset mid-line: async clear, then the phase and vsign restart clean.
    do_reset();
    drive(mk(1, 0, 127, 1, 0, 1, 0, 0));
    @(negedge clk);
    drive(mk(1, 0, 127, 0, 0, 1, 0, 0));
    repeat (4) @(negedge clk);
    check("midreset_pre", ifa.out, 8'sd126);
    #2 rst_n = 1'b0;
    #1 check("midreset_async", ifa.out, 8'sd0);
    @(negedge clk);
    rst_n = 1'b1;
    mr = '{0, 0, 126, 0};
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check($sformatf("midreset_post[%0d]", j), ifa.out, 8'(mr[j]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
